// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// RUN cycle; 32 steps per operation. Signed operations work on magnitudes
// and fix the signs when the final result is written to hi/lo.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [4:0] LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t state, state_next;
  logic [4:0] step_cnt;

  // Magnitude of a value, taken only for signed operations.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic is_signed);
    if (is_signed && (v < 0)) abs_val = $unsigned(-v);
    else                      abs_val = $unsigned(v);
  endfunction

  // Conditional two's complement negation, 32-bit.
  function automatic logic [DATA_W-1:0] cond_neg32(input logic [DATA_W-1:0] v,
                                                   input logic n);
    cond_neg32 = n ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's complement negation, 64-bit.
  function automatic logic [PROD_W-1:0] cond_neg64(input logic [PROD_W-1:0] v,
                                                   input logic n);
    cond_neg64 = n ? (~v + 64'd1) : v;
  endfunction

  // Operand conditioning at the accepting edge
  logic signed [DATA_W-1:0] a_s, b_s;
  logic                     op_signed;
  logic [DATA_W-1:0]        a_mag, b_mag;
  logic                     accept, mt_write, last_edge;

  assign a_s       = operand_a;
  assign b_s       = operand_b;
  assign op_signed = ~op[0];
  assign a_mag     = abs_val(a_s, op_signed);
  assign b_mag     = abs_val(b_s, op_signed);

  // start is only honoured outside RUN; MTHI/MTLO lose to an accepted start.
  assign accept    = start && (state != S_RUN);
  assign mt_write  = (hi_write || lo_write) && (state != S_RUN) && !accept;
  assign last_edge = (state == S_RUN) && (step_cnt == LAST_STEP);

  // Captured operation context and iteration accumulator (p0 stage)
  logic              is_div_p0;
  logic              neg_q_p0;
  logic              neg_r_p0;
  logic              b_zero_p0;
  logic [DATA_W-1:0] mag_p0;
  logic [DATA_W-1:0] acc_hi_p0;
  logic [DATA_W-1:0] acc_lo_p0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; busy/done are direct decodes of the state flops
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (step_cnt == LAST_STEP) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        state_next = start ? S_RUN : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Step counter: 0 on the accepting edge, advances once per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               step_cnt <= 5'd0;
    else if (accept)         step_cnt <= 5'd0;
    else if (state == S_RUN) step_cnt <= step_cnt + 5'd1;
  end

  // One iteration step of the shift-add multiplier or restoring divider
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] step_hi, step_lo;

  always_comb begin
    add_sum = '0;
    shifted = '0;
    fits    = 1'b0;
    step_hi = acc_hi_p0;
    step_lo = acc_lo_p0;
    if (is_div_p0) begin
      // Remainder shifts in the next dividend bit; subtract when divisor fits.
      shifted = {acc_hi_p0, acc_lo_p0[DATA_W-1]};
      fits    = (shifted >= {1'b0, mag_p0});
      step_hi = fits ? DATA_W'(shifted - {1'b0, mag_p0}) : shifted[DATA_W-1:0];
      step_lo = {acc_lo_p0[DATA_W-2:0], fits};
    end else begin
      // Add multiplicand when multiplier LSB is set, then shift right.
      add_sum = {1'b0, acc_hi_p0} + (acc_lo_p0[0] ? {1'b0, mag_p0} : {(DATA_W+1){1'b0}});
      step_hi = add_sum[DATA_W:1];
      step_lo = {add_sum[0], acc_lo_p0[DATA_W-1:1]};
    end
  end

  // Final sign correction applied to the last step's output
  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] quot, rem, res_hi, res_lo;

  always_comb begin
    prod   = cond_neg64({step_hi, step_lo}, neg_q_p0);
    quot   = b_zero_p0 ? {DATA_W{1'b1}} : cond_neg32(step_lo, neg_q_p0);
    rem    = cond_neg32(step_hi, neg_r_p0);
    res_hi = is_div_p0 ? rem  : prod[PROD_W-1:DATA_W];
    res_lo = is_div_p0 ? quot : prod[DATA_W-1:0];
  end

  // Operand capture on accept, one iteration step per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_p0 <= op[1];
      neg_q_p0  <= op_signed & (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
      neg_r_p0  <= op_signed & operand_a[DATA_W-1];
      b_zero_p0 <= (operand_b == '0);
      mag_p0    <= op[1] ? b_mag : a_mag;
      acc_hi_p0 <= '0;
      acc_lo_p0 <= op[1] ? a_mag : b_mag;
    end else if (state == S_RUN) begin
      acc_hi_p0 <= step_hi;
      acc_lo_p0 <= step_lo;
    end
  end

  // Architectural HI/LO: loaded by the final step or by MTHI/MTLO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (last_edge) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_write) begin
      if (hi_write) hi <= write_data;
      if (lo_write) lo <= write_data;
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; operand and result widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 operand_a  input  32  rs value from register file read_data1 (multiplicand/dividend).
REQ-007 operand_b  input  32  rt value from register file read_data2 (multiplier/divisor).
REQ-008 hi_write  input  1  MTHI: load write_data into hi.
REQ-009 lo_write  input  1  MTLO: load write_data into lo.
REQ-010 write_data  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  registered; high while an operation is in progress (CPU stalls MFHI/MFLO/new mult-div).
REQ-012 done  output  1  registered; one-cycle pulse when hi/lo hold a new result.
REQ-013 hi  output  32  HI register (product upper half / remainder).
REQ-014 lo  output  32  LO register (product lower half / quotient).

Function
REQ-015 States SHALL be IDLE, RUN, DONE; DONE lasts exactly one cycle then returns to IDLE unless a start is accepted.
REQ-016 start SHALL be accepted only in IDLE or DONE; op, operand_a, operand_b SHALL be captured on the accepting edge and ignored afterwards.
REQ-017 start asserted in RUN SHALL be ignored, with no effect on state, hi, lo.
REQ-018 After accepting edge E, busy SHALL be 1 for exactly 32 cycles (edges E..E+31); at edge E+32 hi/lo SHALL load the result, busy SHALL fall to 0, done SHALL rise for one cycle.
REQ-019 Computation SHALL be iterative, one shift-add (multiply) or one restoring shift-subtract (divide) step per RUN cycle, 32 steps.
REQ-020 MULTU: {hi,lo} = unsigned 64-bit product.
REQ-021 MULT: operands treated as two's complement; magnitudes multiplied, 64-bit result negated when sign(a) XOR sign(b).
REQ-022 DIVU: lo = floor(a/b), hi = a mod b, unsigned.
REQ-023 DIV: quotient truncated toward zero; quotient negative when sign(a) XOR sign(b); remainder takes the sign of operand_a; |remainder| < |b|.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0x00000000.
REQ-025 Divide by zero (any sign) SHALL take the normal 32-cycle latency and give lo = 0xFFFFFFFF, hi = operand_a as captured.
REQ-026 hi_write/lo_write SHALL take effect on the next edge only when not in RUN and start is not accepted on that edge; otherwise they are dropped.
REQ-027 hi_write and lo_write together SHALL load both registers with write_data.
REQ-028 hi and lo SHALL hold their value at all times except on a result edge (REQ-018) or an accepted write (REQ-026); intermediate iteration state SHALL not be visible on hi/lo.
REQ-029 done SHALL not assert for MTHI/MTLO writes.

Reset
REQ-030 While reset is high, state SHALL be IDLE, busy = 0, done = 0, hi = 0x00000000, lo = 0x00000000, independent of clk.
REQ-031 Reset asserted during RUN SHALL abort the operation; no partial result SHALL reach hi/lo, and done SHALL not pulse after release.
REQ-032 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 32 busy cycles hi = 0xFFFFFFFE, lo = 0x00000001, done pulses once.
REQ-034 MULT -3 x 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-035 DIVU 7 / 0 -> hi = 0x00000007, lo = 0xFFFFFFFF after 32 cycles; DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
REQ-036 Start MULTU 2x3, assert start with op DIVU 9/2 at busy cycle 5 -> ignored; result hi = 0, lo = 6.
REQ-037 Start MULTU 2x3, assert reset at busy cycle 10 -> busy = 0, hi = lo = 0 immediately; no done after release.
REQ-038 In IDLE, hi_write with write_data 0x12345678 -> hi = 0x12345678, lo unchanged; same with start on the same edge -> write dropped, operation starts.
